hub75_scan_engine: RTL and testbench

- Parametrised, fully synchronous HUB75 panel scan controller.
- Drives column/row addressing, pixel-load requests, pixel clock, latch and output enable for binary-coded-modulation bitplanes with global dimming and configurable anti-ghosting blanking.
- Sits between the framebuffer read port, which supplies the pixel bit one cycle after pixel_load, and the panel pins.
- Shifting of the next bitplane overlaps display of the current one.

---
 rtl/hub75_scan_engine_if.sv | 31 +++
 rtl/hub75_scan_engine.sv | 140 ++++++++++++++
 tb/tb_hub75_scan_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_scan_engine_if.sv
// Signal bundle between the HUB75 scan engine, its controller/framebuffer side and the panel pins.
// The master modport is the scan engine; the slave modport is whatever drives enable/brightness and consumes the pins.
interface hub75_scan_engine_if #(
  parameter int COL_BITS  = 6,
  parameter int ROW_BITS  = 4,
  parameter int BIT_DEPTH = 6
) ();
  logic                 enable;
  logic [7:0]           brightness;
  logic [COL_BITS-1:0]  column_address;
  logic                 pixel_load;
  logic                 clk_pixel;
  logic                 row_latch;
  logic                 output_enable;
  logic [ROW_BITS-1:0]  row_address;
  logic [ROW_BITS-1:0]  row_address_active;
  logic [BIT_DEPTH-1:0] brightness_mask;
  logic                 frame_start;

  modport master (
    input  enable, brightness,
    output column_address, pixel_load, clk_pixel, row_latch, output_enable,
           row_address, row_address_active, brightness_mask, frame_start
  );

  modport slave (
    output enable, brightness,
    input  column_address, pixel_load, clk_pixel, row_latch, output_enable,
           row_address, row_address_active, brightness_mask, frame_start
  );
endinterface

// File: rtl/hub75_scan_engine.sv
// HUB75 scan controller: shifts one bitplane of a row while the previously latched plane is displayed,
// with BCM on-times scaled by a global brightness and OE-low guard bands around every latch.
module hub75_scan_engine #(
  parameter int COLUMNS      = 64,
  parameter int COL_BITS     = 6,
  parameter int ROW_BITS     = 4,
  parameter int BIT_DEPTH    = 6,
  parameter int OE_UNIT      = 1,
  parameter int BLANK_CYCLES = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  hub75_scan_engine_if.master bus
);

  localparam int DW = $clog2(OE_UNIT + 1) + BIT_DEPTH;
  localparam int PW = DW + 8;
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [COL_BITS-1:0] LAST_COL   = COL_BITS'(COLUMNS - 1);
  localparam logic [BW-1:0]       BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_OE, BLANK_PRE, LATCH, BLANK_POST} state_t;

  state_t          state;
  logic [DW-1:0]   disp_cnt;
  logic [DW-1:0]   disp_nx;
  logic [BW-1:0]   blank_cnt;

  // Product is kept at full width so the >>8 never loses high bits of the scaled unit.
  function automatic logic [DW-1:0] plane_on_time(input logic [BIT_DEPTH-1:0] mask,
                                                  input logic [7:0] level);
    logic [PW-1:0] unit;
    logic [PW-1:0] prod;
    unit = '0;
    for (int i = 0; i < BIT_DEPTH; i++)
      if (mask[i]) unit = PW'(OE_UNIT) << i;
    prod = unit * PW'(level);
    return DW'(prod >> 8);
  endfunction

  // The counter only moves in cycles where OE is actually high, so blanking never eats display time.
  assign disp_nx = disp_cnt - DW'(bus.output_enable);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      disp_cnt               <= '0;
      blank_cnt              <= '0;
      bus.column_address     <= '0;
      bus.pixel_load         <= 1'b0;
      bus.clk_pixel          <= 1'b0;
      bus.row_latch          <= 1'b0;
      bus.output_enable      <= 1'b0;
      bus.row_address        <= '0;
      bus.row_address_active <= '0;
      bus.brightness_mask    <= BIT_DEPTH'(1);
      bus.frame_start        <= 1'b0;
    end else begin
      disp_cnt          <= disp_nx;
      bus.output_enable <= (disp_nx != '0);
      bus.pixel_load    <= 1'b0;
      bus.row_latch     <= 1'b0;
      bus.frame_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state              <= SHIFT;
            bus.pixel_load     <= 1'b1;
            bus.clk_pixel      <= 1'b0;
            bus.column_address <= '0;
            bus.frame_start    <= (bus.row_address == '0) && (bus.brightness_mask == BIT_DEPTH'(1));
          end
        end
        SHIFT: begin
          if (!bus.clk_pixel) begin
            bus.clk_pixel <= 1'b1;
          end else if (bus.column_address == LAST_COL) begin
            bus.clk_pixel <= 1'b0;
            if (disp_nx == '0) begin
              state             <= BLANK_PRE;
              blank_cnt         <= BLANK_LAST;
              bus.output_enable <= 1'b0;
            end else begin
              state <= WAIT_OE;
            end
          end else begin
            bus.clk_pixel      <= 1'b0;
            bus.pixel_load     <= 1'b1;
            bus.column_address <= bus.column_address + COL_BITS'(1);
          end
        end
        WAIT_OE: begin
          if (disp_cnt == '0) begin
            state             <= BLANK_PRE;
            blank_cnt         <= BLANK_LAST;
            bus.output_enable <= 1'b0;
          end
        end
        BLANK_PRE: begin
          bus.output_enable <= 1'b0;
          if (blank_cnt == '0) begin
            state                  <= LATCH;
            bus.row_latch          <= 1'b1;
            bus.row_address_active <= bus.row_address;
            disp_cnt               <= plane_on_time(bus.brightness_mask, bus.brightness);
            if (bus.brightness_mask[BIT_DEPTH-1]) begin
              bus.brightness_mask <= BIT_DEPTH'(1);
              bus.row_address     <= bus.row_address + ROW_BITS'(1);
            end else begin
              bus.brightness_mask <= bus.brightness_mask << 1;
            end
          end else begin
            blank_cnt <= blank_cnt - BW'(1);
          end
        end
        LATCH: begin
          bus.output_enable <= 1'b0;
          state             <= BLANK_POST;
          blank_cnt         <= BLANK_LAST;
        end
        BLANK_POST: begin
          if (blank_cnt != '0) begin
            bus.output_enable <= 1'b0;
            blank_cnt         <= blank_cnt - BW'(1);
          end else if (bus.enable) begin
            state              <= SHIFT;
            bus.pixel_load     <= 1'b1;
            bus.clk_pixel      <= 1'b0;
            bus.column_address <= '0;
            bus.frame_start    <= (bus.row_address == '0) && (bus.brightness_mask == BIT_DEPTH'(1));
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_engine.sv
// Bench for hub75_scan_engine: cycle-exact shift/latch timing, BCM widths via a latch-driven scoreboard,
// blanking guards, row wrap, async reset and enable drop/resume.
module tb_hub75_scan_engine;
  localparam int COLUMNS = 4, COL_BITS = 2, ROW_BITS = 2, BIT_DEPTH = 6, OE_UNIT = 1, BLANK = 2;
  localparam logic [16:0] RST_OUTS = {2'b00, 4'b0000, 2'b00, 2'b00, 6'b000001, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hub75_scan_engine_if #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .BIT_DEPTH(BIT_DEPTH)) bus ();

  hub75_scan_engine #(
    .COLUMNS(COLUMNS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS),
    .BIT_DEPTH(BIT_DEPTH), .OE_UNIT(OE_UNIT), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.column_address, bus.pixel_load, bus.clk_pixel, bus.row_latch, bus.output_enable,
            bus.row_address, bus.row_address_active, bus.brightness_mask, bus.frame_start};
  endfunction

  // Scoreboard: expected OE width of the previous plane and expected active row, popped at each latch.
  int  exp_w_q[$];
  int  exp_row_q[$];
  bit  mon_on = 1'b0;
  bit  seen;
  int  lat_cnt, oe_cnt, fs_cnt, post;
  bit  post_oe;
  logic [1:0] hist;

  always begin
    @(posedge clk);
    #1;
    if (!reset || !mon_on) begin
      seen = 0; oe_cnt = 0; fs_cnt = 0; lat_cnt = 0; post = 0; post_oe = 0; hist = 2'b00;
    end else begin
      if (bus.frame_start) fs_cnt++;
      if (bus.row_latch) begin
        lat_cnt++;
        check("oe_guard_pre_and_latch", {hist, bus.output_enable}, 0);
        if (seen) begin
          if (exp_w_q.size() == 0) check("width_queue_underrun", 1, 0);
          else check("oe_width", oe_cnt, exp_w_q.pop_front());
        end
        if (exp_row_q.size() == 0) check("row_queue_underrun", 1, 0);
        else check("row_address_active", bus.row_address_active, exp_row_q.pop_front());
        seen = 1; oe_cnt = 0; post = BLANK; post_oe = 0;
      end else begin
        if (bus.output_enable) oe_cnt++;
        if (post > 0) begin
          post_oe |= bus.output_enable;
          post--;
          if (post == 0) check("oe_guard_post", post_oe, 0);
        end
      end
      hist = {hist[0], bus.output_enable};
    end
  end

  typedef struct {
    logic [7:0] bright;
    int         nlat;
    int         fs;
    int         w[6];
  } vec_t;

  task automatic do_reset();
    reset = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] tim[14];
  vec_t       vecs[4];

  initial begin
    int  n, pl_cnt, oe_after, pl_after;
    bit  found;

    tim = '{6'b100100, 6'b010000, 6'b100001, 6'b010001, 6'b100010, 6'b010010, 6'b100011,
            6'b010011, 6'b000011, 6'b000011, 6'b001011, 6'b000011, 6'b000011, 6'b100000};
    vecs[0].bright = 8'd255; vecs[0].nlat = 7;  vecs[0].fs = 1; vecs[0].w = '{0, 1, 3, 7, 15, 31};
    vecs[1].bright = 8'd128; vecs[1].nlat = 7;  vecs[1].fs = 1; vecs[1].w = '{0, 1, 2, 4, 8, 16};
    vecs[2].bright = 8'd64;  vecs[2].nlat = 7;  vecs[2].fs = 1; vecs[2].w = '{0, 0, 1, 2, 4, 8};
    vecs[3].bright = 8'd0;   vecs[3].nlat = 25; vecs[3].fs = 2; vecs[3].w = '{0, 0, 0, 0, 0, 0};

    bus.enable = 1'b0;
    bus.brightness = 8'd0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", outs(), RST_OUTS);
    @(negedge clk) reset = 1'b1;
    pl_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.pixel_load) pl_cnt++;
    end
    check("idle_pixel_load_count", pl_cnt, 0);
    check("idle_outputs", outs(), RST_OUTS);

    // Cycle-exact first plane: enable set here, cycle 1 is the next edge.
    bus.enable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("timing_cycle_%0d", c + 1),
            {bus.pixel_load, bus.clk_pixel, bus.row_latch, bus.frame_start, bus.column_address},
            tim[c]);
    end

    foreach (vecs[v]) begin
      do_reset();
      exp_w_q.delete();
      exp_row_q.delete();
      for (int k = 0; k < vecs[v].nlat; k++) begin
        exp_row_q.push_back((k / BIT_DEPTH) % (1 << ROW_BITS));
        if (k < vecs[v].nlat - 1) exp_w_q.push_back(vecs[v].w[k % BIT_DEPTH]);
      end
      bus.brightness = vecs[v].bright;
      mon_on = 1'b1;
      bus.enable = 1'b1;
      for (int c = 0; c < 3000 && lat_cnt < vecs[v].nlat; c++) begin
        @(posedge clk);
        #2;
      end
      check($sformatf("latch_count_b%0d", vecs[v].bright), lat_cnt, vecs[v].nlat);
      check($sformatf("frame_starts_b%0d", vecs[v].bright), fs_cnt, vecs[v].fs);
      check($sformatf("scoreboard_left_b%0d", vecs[v].bright), exp_w_q.size() + exp_row_q.size(), 0);
      mon_on = 1'b0;
      bus.enable = 1'b0;
    end

    // Async reset in the middle of shifting row 2.
    do_reset();
    bus.brightness = 8'd0;
    bus.enable = 1'b1;
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.row_address == 2 && bus.pixel_load && bus.column_address == 1) found = 1;
    end
    check("reached_row2_shift", found, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", outs(), RST_OUTS);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.frame_start) begin
        found = 1;
        check("restart_row", bus.row_address, 0);
        check("restart_mask", bus.brightness_mask, 1);
      end
    end
    check("restart_frame_start_seen", found, 1);

    // Drop enable while plane 3 is shifting: it must latch and display, then go idle.
    do_reset();
    bus.brightness = 8'd255;
    bus.enable = 1'b1;
    n = 0;
    for (int c = 0; c < 1000 && n < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.row_latch) n++;
    end
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.pixel_load) found = 1;
    end
    check("plane3_shift_started", found && (bus.brightness_mask == 6'b001000), 1);
    bus.enable = 1'b0;
    n = 0; oe_after = 0; pl_after = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (bus.row_latch) n++;
      else if (n > 0) begin
        if (bus.output_enable) oe_after++;
        if (bus.pixel_load) pl_after++;
      end
    end
    check("drop_latch_count", n, 1);
    check("drop_plane3_width", oe_after, 7);
    check("drop_no_pixel_load", pl_after, 0);
    check("drop_idle_oe", bus.output_enable, 0);
    bus.enable = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.pixel_load) begin
        found = 1;
        check("resume_mask", bus.brightness_mask, 6'b010000);
        check("resume_no_frame_start", bus.frame_start, 0);
      end
    end
    check("resume_seen", found, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
